// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Pipelined immediate extender sitting between decode and the ALU /
// branch-target operand muxes. The immediate is extended combinationally on
// the input side and the result (plus its tag) is stored in a two-entry
// elastic buffer: an output register (OR) and a skid register (SK).
//
// Ports
//   CLK        rising-edge clock for all state
//   Reset      synchronous, active-high; discards both buffer entries
//   in_valid   producer offers a word
//   in_ready   unit accepts a word this cycle (registered, = SK empty)
//   in_imm     raw IN_W-bit immediate
//   in_mode    0 zero-ext, 1 sign-ext, 2 upper-load, 3 sign-ext then << SHIFT
//   in_tag     sideband tag, carried unchanged
//   out_valid  result present in OR
//   out_ready  consumer takes the result this cycle
//   out_imm    extended OUT_W-bit result
//   out_tag    tag belonging to out_imm
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PAD_W = OUT_W - IN_W;

  // Buffer occupancy: EMPTY (nothing), ONE (OR valid), FULL (OR and SK valid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  buf_state_t state_q, state_d;

  logic [OUT_W-1:0] or_imm_q, or_imm_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d;
  logic [OUT_W-1:0] sk_imm_q, sk_imm_d;
  logic [TAG_W-1:0] sk_tag_q, sk_tag_d;
  logic             in_ready_q, in_ready_d;

  // ---------------------------------------------------------------------
  // Combinational extension
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] zext_imm;
  logic [OUT_W-1:0] sext_imm;
  logic [OUT_W-1:0] upper_imm;
  logic [OUT_W-1:0] shift_imm;
  logic [OUT_W-1:0] ext_imm;

  assign zext_imm  = {{PAD_W{1'b0}}, in_imm};
  assign sext_imm  = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
  assign upper_imm = {in_imm, {PAD_W{1'b0}}};
  // Shift keeps OUT_W bits, so the top SHIFT bits of the sign-extended
  // value fall off the end by construction.
  assign shift_imm = sext_imm << SHIFT;

  always_comb begin
    ext_imm = zext_imm;
    unique case (in_mode)
      2'd0:    ext_imm = zext_imm;
      2'd1:    ext_imm = sext_imm;
      2'd2:    ext_imm = upper_imm;
      default: ext_imm = shift_imm;
    endcase
  end

  // ---------------------------------------------------------------------
  // Elastic buffer control
  // ---------------------------------------------------------------------
  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d  = state_q;
    or_imm_d = or_imm_q;
    or_tag_d = or_tag_q;
    sk_imm_d = sk_imm_q;
    sk_tag_d = sk_tag_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d  = ONE;
          or_imm_d = ext_imm;
          or_tag_d = in_tag;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          // OR is drained and refilled on the same edge: no bubble.
          or_imm_d = ext_imm;
          or_tag_d = in_tag;
        end else if (in_fire) begin
          state_d  = FULL;
          sk_imm_d = ext_imm;
          sk_tag_d = in_tag;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low while FULL, so only the output side can move.
        if (out_fire) begin
          state_d  = ONE;
          or_imm_d = sk_imm_q;
          or_tag_d = sk_tag_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Registered ready: next-cycle ready is known from the next state, which
    // keeps in_ready free of any combinational path from out_ready.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= EMPTY;
      or_imm_q   <= '0;
      or_tag_q   <= '0;
      sk_imm_q   <= '0;
      sk_tag_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      or_imm_q   <= or_imm_d;
      or_tag_q   <= or_tag_d;
      sk_imm_q   <= sk_imm_d;
      sk_tag_q   <= sk_tag_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_imm   = or_imm_q;
  assign out_tag   = or_tag_q;

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender for the datapath: it takes an IN_W-bit instruction immediate and produces an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, upper-load, or sign-extend-and-shift for branch offsets. Results carry a destination tag. A valid/ready handshake with a two-entry elastic buffer (output register plus skid register) sustains one result per cycle under backpressure. It sits between the decode stage and the ALU/branch-target operand muxes.

## Interface
Parameters:
- IN_W, 16, immediate input width; legal when IN_W ≥ 2.
- OUT_W, 32, result width; OUT_W ≥ IN_W + SHIFT and OUT_W > IN_W.
- SHIFT, 2, left shift applied in mode 3.
- TAG_W, 5, width of the sideband tag carried with each result.

Ports:
- CLK, in, 1, single clock; all state updates on the rising edge.
- Reset, in, 1, synchronous, active-high; clears all state on the edge where it is sampled high.
- in_valid, in, 1, input word present.
- in_ready, out, 1, unit can accept an input this cycle.
- in_imm, in, IN_W, raw immediate.
- in_mode, in, 2, extension mode: 0 zero, 1 sign, 2 upper, 3 sign-shift.
- in_tag, in, TAG_W, passed through unchanged.
- out_valid, out, 1, result present.
- out_ready, in, 1, consumer accepts the result this cycle.
- out_imm, out, OUT_W, extended result.
- out_tag, out, TAG_W, tag belonging to out_imm.

## Operation
- Mode 0: {zeros, in_imm}.
- Mode 1: in_imm[IN_W-1] replicated into bits OUT_W-1..IN_W.
- Mode 2: in_imm << (OUT_W-IN_W); the low bits are zero.
- Mode 3: sign-extend to OUT_W, then << SHIFT, truncated to OUT_W.
- Extension is combinational on the input side. Only the registered result and tag are stored. Mode is not stored.
- Storage is an output register (OR) and a skid register (SK), each with its own valid bit. Buffer states: EMPTY (both clear), ONE (OR valid), FULL (OR and SK valid).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- EMPTY: on input transfer → ONE.
- ONE with output only → EMPTY.
- ONE with input only → FULL; the new word goes to SK.
- ONE with input and output together → ONE; the new word is written into OR.
- FULL with output transfer → ONE; SK moves to OR. No input can be accepted while FULL.
- in_ready = !SK valid, driven from a register. It is not combinational from out_ready.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- out_imm and out_tag stay stable while out_valid && !out_ready.
- In_valid with in_ready low is ignored. The producer must hold the word.

## Timing
- Reset values: out_valid 0, out_imm 0, out_tag 0, in_ready 1, SK cleared.
- Reset mid-operation discards both entries. The cycle after Reset deasserts, the state is EMPTY.
- Latency: an input accepted at edge N appears on out_imm with out_valid high in the cycle after edge N (one cycle).
- Throughput: 1 word/cycle while out_ready stays high.
- in_ready falls in the cycle after the edge that fills SK. It rises in the cycle after the edge that drains SK.
- Simultaneous input and output transfer in ONE keeps out_valid high continuously with no bubble.
- Arithmetic is unsigned bit manipulation only; there is no overflow flag. Mode 3 discards the top SHIFT bits of the sign-extended value.

## Test plan
- Modes with out_ready=1, IN_W=16, OUT_W=32, SHIFT=2: 0x8000 mode0 → 0x00008000; 0x8000 mode1 → 0xFFFF8000; 0x1234 mode2 → 0x12340000; 0xFFFF mode3 → 0xFFFFFFFC; 0x0004 mode3 → 0x00000010. Each appears one cycle after acceptance with the matching tag.
- Streaming: 8 back-to-back inputs, tags 0..7, out_ready=1 → 8 consecutive valid outputs, in order, with in_ready always 1.
- Backpressure: out_ready=0, offer tags 1, 2, 3 → 1 and 2 are accepted and in_ready goes 0 while 3 is held. Raising out_ready → outputs 1, 2, 3 in order, in_ready returns to 1, and out_imm stays stable while stalled.
- Simultaneous in/out in ONE with out_ready toggling every cycle → no loss or duplication; a scoreboard matches all 20 words.
- Reset while FULL → next cycle out_valid 0, in_ready 1, out_imm 0; a subsequent input 0x00FF mode1 → 0x000000FF.
- Parameter sweep IN_W=8, OUT_W=16, SHIFT=1: 0x80 mode1 → 0xFF80; 0x80 mode3 → 0xFF00; 0xAB mode2 → 0xAB00.
